xacc_stage: RTL

XACC_STAGE -- requirements
Module: xacc_stage

---
 rtl/xacc_stage.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/xacc_stage.sv
// xacc_stage: configurable delayed accumulator stage.
//
// A start pulse taken in IDLE latches the configuration. The stage then waits
// D cycles and consumes I iterations of P samples from in0, one per cycle.
// Within an iteration the samples are reduced by modular add (cfg_op=0) or
// signed max (cfg_op=1). out0 is updated with each completed iteration result.
//
// Ports:
//   clk       - sole clock, rising edge
//   rst       - asynchronous active-high reset
//   run       - start pulse, honoured only in IDLE
//   done      - high when idle, low while a run is in progress
//   in0       - sample stream (DATA_W)
//   cfg_iter  - iteration count I
//   cfg_per   - samples per iteration P
//   cfg_delay - start delay D in cycles
//   cfg_op    - 0 = modular add, 1 = signed max
//   out0      - registered per-iteration result
module xacc_stage #(
  parameter int DATA_W = 32,
  parameter int ITER_W = 10,
  parameter int PER_W  = 6,
  parameter int DLY_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  output logic              done,
  input  logic [DATA_W-1:0] in0,
  input  logic [ITER_W-1:0] cfg_iter,
  input  logic [PER_W-1:0]  cfg_per,
  input  logic [DLY_W-1:0]  cfg_delay,
  input  logic              cfg_op,
  output logic [DATA_W-1:0] out0
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_ACC   = 2'd2
  } state_t;

  state_t              state_q,    state_d;
  logic                done_q,     done_d;
  logic [DATA_W-1:0]   out0_q,     out0_d;
  logic [DATA_W-1:0]   acc_q,      acc_d;
  logic [ITER_W-1:0]   iter_q,     iter_d;      // latched I
  logic [PER_W-1:0]    per_q,      per_d;       // latched P
  logic                op_q,       op_d;        // latched op
  logic [DLY_W-1:0]    dly_cnt_q,  dly_cnt_d;
  logic [PER_W-1:0]    per_cnt_q,  per_cnt_d;
  logic [ITER_W-1:0]   iter_cnt_q, iter_cnt_d;

  logic [DATA_W-1:0]   acc_nxt;
  logic                last_in_iter;
  logic                last_iter;

  assign done = done_q;
  assign out0 = out0_q;

  // Only meaningful in ACC, where the latched P and I are known to be non-zero.
  assign last_in_iter = (per_cnt_q == (per_q - PER_W'(1)));
  assign last_iter    = (iter_cnt_q == (iter_q - ITER_W'(1)));

  // Reduction step: the first sample of an iteration replaces the accumulator.
  always_comb begin
    acc_nxt = in0;
    if (per_cnt_q == {PER_W{1'b0}}) begin
      acc_nxt = in0;
    end else if (op_q) begin
      acc_nxt = ($signed(in0) > $signed(acc_q)) ? in0 : acc_q;
    end else begin
      acc_nxt = acc_q + in0;
    end
  end

  // Next-state logic for the controller, counters, accumulator and outputs.
  always_comb begin
    state_d    = state_q;
    done_d     = done_q;
    out0_d     = out0_q;
    acc_d      = acc_q;
    iter_d     = iter_q;
    per_d      = per_q;
    op_d       = op_q;
    dly_cnt_d  = dly_cnt_q;
    per_cnt_d  = per_cnt_q;
    iter_cnt_d = iter_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (run) begin
          iter_d     = cfg_iter;
          per_d      = cfg_per;
          op_d       = cfg_op;
          per_cnt_d  = {PER_W{1'b0}};
          iter_cnt_d = {ITER_W{1'b0}};
          done_d     = 1'b0;
          if ((cfg_iter == {ITER_W{1'b0}}) || (cfg_per == {PER_W{1'b0}})) begin
            // Empty run: stay idle so done is low for this single cycle only.
            state_d = ST_IDLE;
          end else if (cfg_delay != {DLY_W{1'b0}}) begin
            state_d   = ST_DELAY;
            dly_cnt_d = cfg_delay - DLY_W'(1);
          end else begin
            state_d = ST_ACC;
          end
        end else begin
          done_d = 1'b1;
        end
      end

      ST_DELAY: begin
        if (dly_cnt_q == {DLY_W{1'b0}}) begin
          state_d = ST_ACC;
        end else begin
          dly_cnt_d = dly_cnt_q - DLY_W'(1);
        end
      end

      ST_ACC: begin
        acc_d = acc_nxt;
        if (last_in_iter) begin
          out0_d    = acc_nxt;
          per_cnt_d = {PER_W{1'b0}};
          if (last_iter) begin
            state_d    = ST_IDLE;
            done_d     = 1'b1;
            iter_cnt_d = {ITER_W{1'b0}};
          end else begin
            iter_cnt_d = iter_cnt_q + ITER_W'(1);
          end
        end else begin
          per_cnt_d = per_cnt_q + PER_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
    endcase
  end

  // State register; reset aborts any run and clears all state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      done_q     <= 1'b1;
      out0_q     <= {DATA_W{1'b0}};
      acc_q      <= {DATA_W{1'b0}};
      iter_q     <= {ITER_W{1'b0}};
      per_q      <= {PER_W{1'b0}};
      op_q       <= 1'b0;
      dly_cnt_q  <= {DLY_W{1'b0}};
      per_cnt_q  <= {PER_W{1'b0}};
      iter_cnt_q <= {ITER_W{1'b0}};
    end else begin
      state_q    <= state_d;
      done_q     <= done_d;
      out0_q     <= out0_d;
      acc_q      <= acc_d;
      iter_q     <= iter_d;
      per_q      <= per_d;
      op_q       <= op_d;
      dly_cnt_q  <= dly_cnt_d;
      per_cnt_q  <= per_cnt_d;
      iter_cnt_q <= iter_cnt_d;
    end
  end

endmodule
